// File: rtl/linreg_coeff_engine.sv
// linreg_coeff_engine: streams N = 2**LOG2N signed (x, y) pairs, accumulates
// the regression sums and produces slope b1 and intercept b0 in signed
// Q(OW-FRAC).FRAC, using a one-bit-per-cycle restoring divider.
// Optional macro COEFF_ROUND_EN: the divider computes one extra quotient bit and
// the slope magnitude is rounded half away from zero (one extra cycle of latency).
module linreg_coeff_engine #(
  parameter int DW    = 16,
  parameter int LOG2N = 2,
  parameter int FRAC  = 8,
  parameter int OW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  output logic                 busy,
  output logic                 done,
  output logic signed [OW-1:0] b1,
  output logic signed [OW-1:0] b0,
  output logic                 err,
  output logic                 sat
);

  localparam int XW  = DW + LOG2N;          // SX, SY width
  localparam int PW  = 2 * DW;              // single product width
  localparam int XXW = 2 * DW + LOG2N;      // SXX, SXY width
  localparam int NW  = 2 * DW + 2 * LOG2N + 1;
`ifdef COEFF_ROUND_EN
  localparam int DSH = FRAC + 1;            // extra bit used for rounding
`else
  localparam int DSH = FRAC;
`endif
  localparam int QW  = NW + DSH;            // dividend / quotient width = divide cycles
  localparam int CW  = $clog2(QW + 1);
  localparam int BW  = OW + DW + LOG2N + 2; // intercept arithmetic width
  localparam int RW  = QW + 1;
  localparam int SW  = (RW > BW) ? RW : BW; // common width for saturation

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_PREP  = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_B0    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]              state_reg;
  logic [LOG2N-1:0]        cnt_reg;
  logic signed [XW-1:0]    sx_reg, sy_reg;
  logic signed [XXW-1:0]   sxx_reg, sxy_reg;
  logic [NW-1:0]           den_reg;
  logic [NW-1:0]           rem_reg;
  logic [QW-1:0]           dq_reg;     // dividend shifts out, quotient shifts in
  logic                    neg_reg;
  logic                    dz_reg;
  logic [CW-1:0]           dcnt_reg;
  logic signed [OW-1:0]    b1_reg, b0_reg;
  logic                    err_reg, sat_reg;

  // Saturate a wide signed value to OW bits; MSB of the result flags clipping.
  function automatic logic [OW:0] clip_fn(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = '0;
    hi[OW-2:0] = '1;
    lo = ~hi;
    if (v > hi)
      clip_fn = {1'b1, 1'b0, {(OW-1){1'b1}}};
    else if (v < lo)
      clip_fn = {1'b1, 1'b1, {(OW-1){1'b0}}};
    else
      clip_fn = {1'b0, v[OW-1:0]};
  endfunction

  // Sample products, exact in 2*DW bits.
  logic signed [PW-1:0] xx_w, xy_w;
  assign xx_w = PW'(x_in) * PW'(x_in);
  assign xy_w = PW'(x_in) * PW'(y_in);

  // Numerator / denominator of the slope, evaluated while in PREP.
  logic signed [NW-1:0] sx_w, sy_w, sxx_w, sxy_w, num_w, den_w;
  logic [NW-1:0]        num_mag;
  assign sx_w    = NW'(sx_reg);
  assign sy_w    = NW'(sy_reg);
  assign sxx_w   = NW'(sxx_reg);
  assign sxy_w   = NW'(sxy_reg);
  assign num_w   = (sxy_w <<< LOG2N) - sx_w * sy_w;
  assign den_w   = (sxx_w <<< LOG2N) - sx_w * sx_w;
  assign num_mag = num_w[NW-1] ? -num_w : num_w;

  // Restoring divider step: bring down the next dividend bit and trial-subtract.
  logic [NW:0]   trial_w;
  logic [NW-1:0] diff_w;
  logic          fits_w;
  assign trial_w = {rem_reg, dq_reg[QW-1]};
  assign fits_w  = (trial_w >= {1'b0, den_reg});
  assign diff_w  = trial_w[NW-1:0] - den_reg;

  // Quotient magnitude, optionally rounded half away from zero.
  logic [QW-1:0] mag_w;
`ifdef COEFF_ROUND_EN
  assign mag_w = QW'(({1'b0, dq_reg} + {{QW{1'b0}}, 1'b1}) >> 1);
`else
  assign mag_w = dq_reg;
`endif

  logic signed [SW-1:0] mag_ext, q_w, b0_x;
  logic signed [BW-1:0] sx_b, sy_b, b1_b, b0_full;
  logic [OW:0]          b1_clip, b0_clip;

  // Slope and intercept with saturation; the slope is forced to zero when den was zero.
  always_comb begin
    mag_ext = SW'(mag_w);
    if (dz_reg)
      q_w = '0;
    else if (neg_reg)
      q_w = -mag_ext;
    else
      q_w = mag_ext;
    b1_clip = clip_fn(q_w);
    sx_b    = BW'(sx_reg);
    sy_b    = BW'(sy_reg);
    b1_b    = BW'($signed(b1_clip[OW-1:0]));
    b0_full = (sy_b <<< FRAC) - b1_b * sx_b;
    b0_x    = SW'(b0_full >>> LOG2N);
    b0_clip = clip_fn(b0_x);
  end

  // Control FSM with accumulators, divider and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      sx_reg    <= '0;
      sy_reg    <= '0;
      sxx_reg   <= '0;
      sxy_reg   <= '0;
      den_reg   <= '0;
      rem_reg   <= '0;
      dq_reg    <= '0;
      neg_reg   <= 1'b0;
      dz_reg    <= 1'b0;
      dcnt_reg  <= '0;
      b1_reg    <= '0;
      b0_reg    <= '0;
      err_reg   <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            cnt_reg   <= '0;
            sx_reg    <= '0;
            sy_reg    <= '0;
            sxx_reg   <= '0;
            sxy_reg   <= '0;
            err_reg   <= 1'b0;
            sat_reg   <= 1'b0;
            state_reg <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            sx_reg  <= sx_reg + XW'(x_in);
            sy_reg  <= sy_reg + XW'(y_in);
            sxx_reg <= sxx_reg + XXW'(xx_w);
            sxy_reg <= sxy_reg + XXW'(xy_w);
            cnt_reg <= cnt_reg + 1'b1;
            if (&cnt_reg)
              state_reg <= S_PREP;
          end
        end
        S_PREP: begin
          den_reg   <= den_w;
          rem_reg   <= '0;
          dq_reg    <= {num_mag, {DSH{1'b0}}};
          neg_reg   <= num_w[NW-1];
          dz_reg    <= (den_w == '0);
          dcnt_reg  <= CW'(QW - 1);
          state_reg <= S_DIV;
        end
        S_DIV: begin
          rem_reg <= fits_w ? diff_w : trial_w[NW-1:0];
          dq_reg  <= {dq_reg[QW-2:0], fits_w};
          if (dcnt_reg == '0)
            state_reg <= S_B0;
          else
            dcnt_reg <= dcnt_reg - 1'b1;
        end
        S_B0: begin
          b1_reg    <= b1_clip[OW-1:0];
          b0_reg    <= b0_clip[OW-1:0];
          err_reg   <= dz_reg;
          sat_reg   <= b1_clip[OW] | b0_clip[OW];
          state_reg <= S_DONE;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state_reg == S_ACCUM);
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);
  assign b1       = b1_reg;
  assign b0       = b0_reg;
  assign err      = err_reg;
  assign sat      = sat_reg;

endmodule

// File: tb/tb_linreg_coeff_engine.sv
// tb_linreg_coeff_engine: directed vectors with hand-computed coefficients,
// latency, handshake and mid-run reset checks.
module tb_linreg_coeff_engine;

  localparam int DW    = 16;
  localparam int LOG2N = 2;
  localparam int FRAC  = 8;
  localparam int OW    = 16;
  localparam int NW    = 2 * DW + 2 * LOG2N + 1;
  localparam int DIVW  = NW + FRAC;
`ifdef COEFF_ROUND_EN
  localparam int LAT = DIVW + 3;
`else
  localparam int LAT = DIVW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_in = '0;
  logic [DW-1:0] y_in = '0;
  logic          busy, done, err, sat;
  logic [OW-1:0] b1, b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] xv [4];
  logic [15:0] yv [4];

  linreg_coeff_engine #(.DW(DW), .LOG2N(LOG2N), .FRAC(FRAC), .OW(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .busy(busy), .done(done), .b1(b1), .b0(b0),
    .err(err), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Drive a start pulse from IDLE, optionally with a competing in_valid.
  task automatic kick(input string tag, input bit with_valid);
    start = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      x_in = 16'd9;
      y_in = 16'd9;
    end
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    check({tag, ".busy_run"}, busy, 1'b1);
  endtask

  // Present the four pairs in xv/yv with 'gap' idle cycles before each one.
  task automatic feed(input string tag, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      x_in = xv[i];
      y_in = yv[i];
      if (i == 0 || i == 3) check($sformatf("%s.rdy%0d", tag, i), in_ready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag, input int gap, input bit hold, input bit with_valid,
                     input int div_start, input bit done_start,
                     input logic [15:0] e_b1, input logic [15:0] e_b0,
                     input bit e_err, input bit e_sat);
    int edges;
    kick(tag, with_valid);
    feed(tag, gap);
    if (hold) begin
      in_valid = 1'b1;
      x_in = 16'd100;
      y_in = 16'd100;
    end else begin
      in_valid = 1'b0;
    end
    check({tag, ".rdy_after"}, in_ready, 1'b0);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk); #1;
      edges++;
      start = (div_start != 0) && (edges == div_start);
      if (done) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check({tag, ".latency"}, edges, LAT);
    check({tag, ".b1"}, b1, e_b1);
    check({tag, ".b0"}, b0, e_b0);
    check({tag, ".err"}, err, e_err);
    check({tag, ".sat"}, sat, e_sat);
    start = done_start;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    int seen;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.b1", b1, 16'h0);
    check("rst.b0", b0, 16'h0);
    check("rst.err", err, 1'b0);
    check("rst.sat", sat, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.rdy", in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: y = 2x + 1
    xv = '{16'd1, 16'd2, 16'd3, 16'd4}; yv = '{16'd3, 16'd5, 16'd7, 16'd9};
    run("t1", 0, 1'b0, 1'b0, 0, 1'b0, 16'h0200, 16'h0100, 1'b0, 1'b0);
    // 2: y = -2x + 6
    xv = '{16'd0, 16'd1, 16'd2, 16'd3}; yv = '{16'd6, 16'd4, 16'd2, 16'd0};
    run("t2", 0, 1'b0, 1'b0, 0, 1'b0, 16'hFE00, 16'h0600, 1'b0, 1'b0);
    // 3: all x equal, start coincides with in_valid in IDLE
    xv = '{16'd5, 16'd5, 16'd5, 16'd5}; yv = '{16'd1, 16'd2, 16'd3, 16'd4};
    run("t3", 0, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 16'h0280, 1'b1, 1'b0);
    // 4: fractional slope (truncated or rounded)
    xv = '{16'd0, 16'd1, 16'd2, 16'd3}; yv = '{16'd0, 16'd0, 16'd0, 16'd1};
`ifdef COEFF_ROUND_EN
    run("t4", 0, 1'b0, 1'b0, 0, 1'b0, 16'h004D, 16'hFFCC, 1'b0, 1'b0);
`else
    run("t4", 0, 1'b0, 1'b0, 0, 1'b0, 16'h004C, 16'hFFCE, 1'b0, 1'b0);
`endif
    // 5: saturation; start during DONE is ignored
    xv = '{16'd0, 16'd0, 16'd0, 16'd1}; yv = '{16'd0, 16'd0, 16'd0, 16'd32767};
    run("t5", 0, 1'b0, 1'b0, 0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);

    // 6a: gapped input, in_valid held after the 4th pair
    xv = '{16'd1, 16'd2, 16'd3, 16'd4}; yv = '{16'd3, 16'd5, 16'd7, 16'd9};
    run("t6a", 2, 1'b1, 1'b0, 0, 1'b0, 16'h0200, 16'h0100, 1'b0, 1'b0);
    // 6b: start pulsed during DIV
    xv = '{16'd0, 16'd1, 16'd2, 16'd3}; yv = '{16'd6, 16'd4, 16'd2, 16'd0};
    run("t6b", 0, 1'b0, 1'b0, 10, 1'b0, 16'hFE00, 16'h0600, 1'b0, 1'b0);
    // 6c: reset in the middle of DIV
    xv = '{16'd1, 16'd2, 16'd3, 16'd4}; yv = '{16'd3, 16'd5, 16'd7, 16'd9};
    kick("t6c", 1'b0);
    feed("t6c", 0);
    in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check("t6c.b1", b1, 16'h0);
    check("t6c.b0", b0, 16'h0);
    check("t6c.err", err, 1'b0);
    check("t6c.sat", sat, 1'b0);
    check("t6c.busy", busy, 1'b0);
    check("t6c.done", done, 1'b0);
    check("t6c.rdy", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("t6c.nodone", seen, 0);
    // 6d: a fresh run after the abort
    run("t6d", 0, 1'b0, 1'b0, 0, 1'b0, 16'h0200, 16'h0100, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
